// File: rtl/hex_digits_arbiter.sv
// hex_digits_arbiter
// Six-digit seven-segment display shared by two writers: the CPU, which writes
// through an Avalon-MM slave port, and the game score path, which uses a
// req/ack handshake. At most one digit write commits per clock. When both
// writers are pending, a round-robin choice picks the winner. The digit bank
// is decoded to active-low segment drive for HEX0..HEX5.
//
// Handshakes:
//   Game path: game_req is a "valid" that is held, together with game_digit
//   and game_value, until game_ack. game_ack is a one-cycle "consumed" pulse.
//   The requester is never considered pending in the cycle game_ack is high,
//   so two acks can never be back to back. A game_req that is still high
//   after the ack is treated as a new request.
//   CPU path: a write to address 0 is always accepted with zero wait states.
//   It parks an index/value pair in a one-deep pending slot, and a newer
//   write replaces an older pair that has not yet committed.

module hex_digits_arbiter (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  input  logic        game_req,
  input  logic [2:0]  game_digit,
  input  logic [3:0]  game_value,
  output logic        game_ack,
  output logic [41:0] hex_segs
);

  // Identity of the last winner of a contended cycle.
  typedef enum logic {
    GRANT_CPU  = 1'b0,
    GRANT_GAME = 1'b1
  } grant_t;

  localparam logic [1:0] ADDR_DIGIT  = 2'd0;
  localparam logic [1:0] ADDR_CTRL   = 2'd1;
  localparam logic [1:0] ADDR_STATUS = 2'd2;
  localparam logic [1:0] ADDR_DROP   = 2'd3;

  localparam logic [1:0] CTRL_RESET  = 2'b10;
  localparam logic [2:0] NUM_DIGITS  = 3'd6;

  // ------------------------------------------------------------------
  // Register state
  // ------------------------------------------------------------------
  logic [5:0][3:0] digit_bank;
  logic            cpu_pend;
  logic [2:0]      cpu_pend_idx;
  logic [3:0]      cpu_pend_val;
  logic [1:0]      ctrl;
  logic [7:0]      drop_cnt;
  logic [2:0]      last_idx;
  grant_t          last_grant;

  // ------------------------------------------------------------------
  // Bus decode
  // ------------------------------------------------------------------
  logic bus_write;
  logic wr_digit;
  logic wr_ctrl;
  logic wr_drop;

  assign bus_write = chipselect & ~write_n;
  assign wr_digit  = bus_write && (address == ADDR_DIGIT);
  assign wr_ctrl   = bus_write && (address == ADDR_CTRL);
  assign wr_drop   = bus_write && (address == ADDR_DROP);

  logic cpu_only;
  logic blank;

  assign cpu_only = ctrl[0];
  assign blank    = ctrl[1];

  // Bits of writedata that carry no meaning for any register.
  logic unused_wdata;
  assign unused_wdata = ^{writedata[31:8], writedata[3]};

  // ------------------------------------------------------------------
  // Arbitration
  // ------------------------------------------------------------------
  logic game_pend;
  logic cpu_grant;
  logic game_grant;
  logic game_drop;
  logic contended;

  // The ack cycle masks the game request so that an ack is never followed
  // directly by another ack.
  assign game_pend = game_req & ~game_ack;

  // Choose this cycle's single committer. In cpu_only mode the game request
  // is discarded rather than granted, and the CPU is treated as uncontended.
  always_comb begin
    cpu_grant  = 1'b0;
    game_grant = 1'b0;
    game_drop  = 1'b0;
    contended  = 1'b0;
    if (cpu_only) begin
      game_drop = game_pend;
      cpu_grant = cpu_pend;
    end else if (cpu_pend && game_pend) begin
      contended = 1'b1;
      if (last_grant == GRANT_GAME) begin
        cpu_grant = 1'b1;
      end else begin
        game_grant = 1'b1;
      end
    end else begin
      cpu_grant  = cpu_pend;
      game_grant = game_pend;
    end
  end

  // ------------------------------------------------------------------
  // Commit path
  // ------------------------------------------------------------------
  logic       commit_en;
  logic [2:0] commit_idx;
  logic [3:0] commit_val;

  // Mux the winner's index/value onto one commit port.
  always_comb begin
    commit_en  = cpu_grant | game_grant;
    commit_idx = game_digit;
    commit_val = game_value;
    if (cpu_grant) begin
      commit_idx = cpu_pend_idx;
      commit_val = cpu_pend_val;
    end
  end

  // CPU pending slot. A new write is loaded even in the cycle the old pair
  // commits, so that pair goes out and the new one stays pending.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cpu_pend     <= 1'b0;
      cpu_pend_idx <= 3'd0;
      cpu_pend_val <= 4'd0;
    end else if (wr_digit) begin
      cpu_pend     <= 1'b1;
      cpu_pend_idx <= writedata[2:0];
      cpu_pend_val <= writedata[7:4];
    end else if (cpu_grant) begin
      cpu_pend     <= 1'b0;
    end
  end

  // Round-robin memory and the one-cycle game acknowledge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_grant <= GRANT_GAME;
      game_ack   <= 1'b0;
    end else begin
      game_ack <= game_grant | game_drop;
      if (contended) begin
        last_grant <= cpu_grant ? GRANT_CPU : GRANT_GAME;
      end
    end
  end

  // Digit bank write. Indices 6 and 7 complete the request but store nothing.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      digit_bank <= '0;
      last_idx   <= 3'd0;
    end else if (commit_en) begin
      last_idx <= commit_idx;
      if (commit_idx < NUM_DIGITS) begin
        for (int k = 0; k < 6; k++) begin
          if (commit_idx == 3'(k)) begin
            digit_bank[k] <= commit_val;
          end
        end
      end
    end
  end

  // Control register and the saturating discard counter. A clear takes
  // priority over an increment in the same cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ctrl     <= CTRL_RESET;
      drop_cnt <= 8'd0;
    end else begin
      if (wr_ctrl) begin
        ctrl <= writedata[1:0];
      end
      if (wr_drop) begin
        drop_cnt <= 8'd0;
      end else if (game_drop && (drop_cnt != 8'hFF)) begin
        drop_cnt <= drop_cnt + 8'd1;
      end
    end
  end

  // ------------------------------------------------------------------
  // Read mux (zero wait states)
  // ------------------------------------------------------------------
  // Combinational read data from the address and current register state.
  always_comb begin
    readdata = 32'd0;
    case (address)
      ADDR_CTRL:   readdata = {30'd0, ctrl};
      ADDR_STATUS: readdata = {25'd0, last_idx, 2'b00, game_req, cpu_pend};
      ADDR_DROP:   readdata = {24'd0, drop_cnt};
      default:     readdata = 32'd0;
    endcase
  end

  // ------------------------------------------------------------------
  // Segment decode
  // ------------------------------------------------------------------
  // Active-low hex font, bit order g..a.
  function automatic logic [6:0] seg7(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0:    s = 7'b1000000;
      4'h1:    s = 7'b1111001;
      4'h2:    s = 7'b0100100;
      4'h3:    s = 7'b0110000;
      4'h4:    s = 7'b0011001;
      4'h5:    s = 7'b0010010;
      4'h6:    s = 7'b0000010;
      4'h7:    s = 7'b1111000;
      4'h8:    s = 7'b0000000;
      4'h9:    s = 7'b0010000;
      4'hA:    s = 7'b0001000;
      4'hB:    s = 7'b0000011;
      4'hC:    s = 7'b1000110;
      4'hD:    s = 7'b0100001;
      4'hE:    s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  // Drive all six displays from the bank, or hold them dark while blanked.
  always_comb begin
    hex_segs = '1;
    if (!blank) begin
      for (int k = 0; k < 6; k++) begin
        hex_segs[7*k +: 7] = seg7(digit_bank[k]);
      end
    end
  end

endmodule

// File: tb/tb_hex_digits_arbiter.sv
// Testbench for hex_digits_arbiter: directed steps followed by a random phase,
// every cycle compared against a transaction-level model of the display.

module tb_hex_digits_arbiter;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        game_req;
  logic [2:0]  game_digit;
  logic [3:0]  game_value;
  logic        game_ack;
  logic [41:0] hex_segs;

  always #5 clk = ~clk;

  hex_digits_arbiter dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .game_req   (game_req),
    .game_digit (game_digit),
    .game_value (game_value),
    .game_ack   (game_ack),
    .hex_segs   (hex_segs)
  );

  int n_asserts = 0;
  int n_fail    = 0;

  // Standard active-low hex font, g..a.
  localparam logic [6:0] SEG_TAB [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

  // ---------------- reference model ----------------
  int       m_dig [6];
  bit       m_cpu_pend;
  int       m_cpu_idx;
  int       m_cpu_val;
  bit [1:0] m_ctrl;
  int       m_drop;
  bit       m_prefer_cpu;
  bit       m_ack;
  int       m_last_idx;
  int       m_cpu_commits;
  int       m_game_commits;

  function automatic void model_reset();
    foreach (m_dig[k]) m_dig[k] = 0;
    m_cpu_pend   = 0;
    m_cpu_idx    = 0;
    m_cpu_val    = 0;
    m_ctrl       = 2'b10;
    m_drop       = 0;
    m_prefer_cpu = 1;
    m_ack        = 0;
    m_last_idx   = 0;
  endfunction

  // Advance the model by one clock using the inputs presented for that edge.
  function automatic void model_step();
    bit wr, game_wants, cpu_wants, cpu_win, game_win, drop;
    wr         = chipselect && !write_n;
    game_wants = game_req && !m_ack;
    cpu_wants  = m_cpu_pend;
    cpu_win    = 0;
    game_win   = 0;
    drop       = 0;
    if (m_ctrl[0]) begin
      drop    = game_wants;
      cpu_win = cpu_wants;
    end else if (cpu_wants && game_wants) begin
      cpu_win      = m_prefer_cpu;
      game_win     = !m_prefer_cpu;
      m_prefer_cpu = !m_prefer_cpu;
    end else begin
      cpu_win  = cpu_wants;
      game_win = game_wants;
    end
    if (cpu_win) begin
      if (m_cpu_idx < 6) m_dig[m_cpu_idx] = m_cpu_val;
      m_last_idx = m_cpu_idx;
      m_cpu_pend = 0;
      m_cpu_commits++;
    end
    if (game_win) begin
      if (int'(game_digit) < 6) m_dig[game_digit] = int'(game_value);
      m_last_idx = int'(game_digit);
      m_game_commits++;
    end
    m_ack = game_win || drop;
    if (drop && m_drop < 255) m_drop++;
    if (wr) begin
      case (address)
        2'd0: begin
          m_cpu_pend = 1;
          m_cpu_idx  = int'(writedata[2:0]);
          m_cpu_val  = int'(writedata[7:4]);
        end
        2'd1: m_ctrl = writedata[1:0];
        2'd3: m_drop = 0;
        default: ;
      endcase
    end
  endfunction

  function automatic logic [41:0] exp_segs();
    logic [41:0] r;
    r = '1;
    if (!m_ctrl[1]) begin
      for (int k = 0; k < 6; k++) r[7*k +: 7] = SEG_TAB[m_dig[k]];
    end
    return r;
  endfunction

  function automatic logic [31:0] exp_rd(input logic [1:0] a);
    logic [31:0] r;
    case (a)
      2'd1:    r = {30'd0, m_ctrl};
      2'd2:    r = {25'd0, 3'(m_last_idx), 2'b00, game_req, m_cpu_pend};
      2'd3:    r = 32'(m_drop);
      default: r = 32'd0;
    endcase
    return r;
  endfunction

  // ---------------- scoreboard ----------------
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    check("segs", {22'd0, hex_segs}, {22'd0, exp_segs()});
    check("game_ack", {63'd0, game_ack}, {63'd0, m_ack});
    for (int a = 0; a < 4; a++) begin
      address = 2'(a);
      #1;
      check($sformatf("readdata_a%0d", a), {32'd0, readdata}, {32'd0, exp_rd(2'(a))});
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic bus_idle();
    chipselect = 1'b0;
    write_n    = 1'b1;
    address    = 2'd0;
    writedata  = 32'd0;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check_all();
    bus_idle();
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    address    = a;
    chipselect = 1'b1;
    write_n    = 1'b0;
    writedata  = d;
    tick();
  endtask

  task automatic read_status(output logic [31:0] d);
    address = 2'd2;
    #1;
    d = readdata;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] st;
    int acks;
    int cpu_done;
    bit prev_pend;
    bit prev_ack;

    reset_n    = 1'b0;
    game_req   = 1'b0;
    game_digit = 3'd0;
    game_value = 4'd0;
    bus_idle();
    model_reset();
    m_cpu_commits  = 0;
    m_game_commits = 0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("reset_segs", {22'd0, hex_segs}, {22'd0, 42'h3FF_FFFF_FFFF});
    check_all();
    reset_n = 1'b1;

    // Unblank: all digits show 0
    bus_write(2'd1, 32'd0);
    check("zeros", {22'd0, hex_segs}, {22'd0, {6{7'b1000000}}});

    // CPU write index 3, value 5: two-cycle latency
    bus_write(2'd0, 32'h0000_0053);
    read_status(st);
    check("cpu_pend_set", {63'd0, st[0]}, 64'd1);
    check("hex3_not_yet", {57'd0, hex_segs[27:21]}, {57'd0, 7'b1000000});
    tick();
    read_status(st);
    check("cpu_pend_clear", {63'd0, st[0]}, 64'd0);
    check("hex3_5", {57'd0, hex_segs[27:21]}, {57'd0, 7'b0010010});
    check("last_idx_3", {61'd0, st[6:4]}, 64'd3);

    // Game request digit 2 = A, uncontended
    game_req = 1'b1; game_digit = 3'd2; game_value = 4'hA;
    tick();
    check("game_ack_pulse", {63'd0, game_ack}, 64'd1);
    check("hex2_A", {57'd0, hex_segs[20:14]}, {57'd0, 7'b0001000});
    game_req = 1'b0;
    tick();
    check("game_ack_one_cycle", {63'd0, game_ack}, 64'd0);

    // First tie goes to the CPU, the second one to the game
    bus_write(2'd0, 32'h0000_0041);
    game_req = 1'b1; game_digit = 3'd4; game_value = 4'h7;
    tick();
    read_status(st);
    check("tie1_game_waits", {63'd0, game_ack}, 64'd0);
    check("tie1_cpu_done", {63'd0, st[0]}, 64'd0);
    tick();
    check("tie1_game_next", {63'd0, game_ack}, 64'd1);
    game_req = 1'b0;
    bus_write(2'd0, 32'h0000_00C0);
    game_req = 1'b1; game_digit = 3'd5; game_value = 4'hE;
    tick();
    read_status(st);
    check("tie2_game_wins", {63'd0, game_ack}, 64'd1);
    check("tie2_cpu_waits", {63'd0, st[0]}, 64'd1);
    game_req = 1'b0;
    tick();

    // Both requesters busy: four commits each within eight cycles
    acks = 0; cpu_done = 0; prev_pend = 0; prev_ack = 0;
    game_req = 1'b1;
    game_digit = 3'($urandom_range(0, 5)); game_value = 4'($urandom_range(0, 15));
    for (int i = 0; i < 8; i++) begin
      if (i % 2 == 0) begin
        address = 2'd0; chipselect = 1'b1; write_n = 1'b0;
        writedata = {24'd0, 4'($urandom_range(0, 15)), 1'b0, 3'(i / 2)};
      end
      tick();
      check("ack_not_back_to_back", {63'd0, prev_ack & game_ack}, 64'd0);
      prev_ack = game_ack;
      if (game_ack) begin
        acks++;
        game_digit = 3'($urandom_range(0, 5)); game_value = 4'($urandom_range(0, 15));
      end
      read_status(st);
      if (prev_pend && !st[0]) cpu_done++;
      prev_pend = st[0];
    end
    game_req = 1'b0;
    check("busy_game_commits", 64'(acks), 64'd4);
    check("busy_cpu_commits", 64'(cpu_done), 64'd4);
    tick();

    // cpu_only: 300 game requests discarded, counter saturates
    bus_write(2'd1, 32'd1);
    acks = 0;
    game_req = 1'b1; game_digit = 3'd0; game_value = 4'hF;
    for (int i = 0; i < 700 && acks < 300; i++) begin
      if (i == 10) begin
        address = 2'd0; chipselect = 1'b1; write_n = 1'b0; writedata = 32'h0000_0071;
      end
      tick();
      if (game_ack) begin
        acks++;
        game_digit = 3'($urandom_range(0, 7)); game_value = 4'($urandom_range(0, 15));
      end
    end
    game_req = 1'b0;
    check("cpu_only_acks", 64'(acks), 64'd300);
    tick();
    address = 2'd3; #1;
    check("drop_saturated", {32'd0, readdata}, 64'd255);
    bus_write(2'd3, 32'd0);
    address = 2'd3; #1;
    check("drop_cleared", {32'd0, readdata}, 64'd0);
    bus_write(2'd1, 32'd0);

    // Index 7 from both requesters completes without touching the bank
    game_req = 1'b1; game_digit = 3'd7; game_value = 4'h3;
    bus_write(2'd0, 32'h0000_0097);
    check("idx7_game_ack", {63'd0, game_ack}, 64'd1);
    game_req = 1'b0;
    tick();
    read_status(st);
    check("idx7_cpu_done", {63'd0, st[0]}, 64'd0);
    check("idx7_last_idx", {61'd0, st[6:4]}, 64'd7);

    // Random traffic
    for (int i = 0; i < 500; i++) begin
      if (game_req && game_ack) begin
        game_req = 1'($urandom_range(0, 1));
        game_digit = 3'($urandom_range(0, 7)); game_value = 4'($urandom_range(0, 15));
      end else if (!game_req && $urandom_range(0, 1) == 1) begin
        game_req = 1'b1;
        game_digit = 3'($urandom_range(0, 7)); game_value = 4'($urandom_range(0, 15));
      end
      if ($urandom_range(0, 2) == 0) begin
        chipselect = 1'b1; write_n = 1'b0;
        writedata = $urandom;
        case ($urandom_range(0, 9))
          0:       begin address = 2'd1; writedata[1] = ($urandom_range(0, 3) == 0); end
          1:       address = 2'd3;
          2:       address = 2'd2;
          default: address = 2'd0;
        endcase
      end
      tick();
    end
    game_req = 1'b0;
    bus_write(2'd1, 32'd0);

    // Reset in the middle of a handshake
    game_req = 1'b1; game_digit = 3'd0; game_value = 4'h5;
    bus_write(2'd0, 32'h0000_0032);
    check("pre_reset_ack", {63'd0, game_ack}, 64'd1);
    reset_n = 1'b0;
    model_reset();
    #1;
    check("reset_ack_drops", {63'd0, game_ack}, 64'd0);
    check("reset_segs_blank", {22'd0, hex_segs}, {22'd0, 42'h3FF_FFFF_FFFF});
    address = 2'd1; #1;
    check("reset_ctrl", {32'd0, readdata}, 64'd2);
    game_req = 1'b0;
    address = 2'd2; #1;
    check("reset_status", {32'd0, readdata}, 64'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    tick();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
